fetch_stage: RTL and testbench

- LC-3b instruction fetch stage; sits directly upstream of the decode stage.
- Holds the PC and issues reads on a multi-cycle instruction-memory handshake.
- Presents npc/ir/valid registered outputs that decode consumes each cycle.
- Honours a downstream stall and a redirect from the branch/jump resolution logic, which squashes wrong-path fetches.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// master = fetch stage side, slave = memory/decode/control side.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic [15:0] npc;
  logic [15:0] ir;
  logic        valid;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata, imem_resp,
    output imem_read, imem_address, npc, ir, valid
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata, imem_resp,
    input  imem_read, imem_address, npc, ir, valid
  );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage.
// Keeps the PC, issues multi-cycle instruction-memory reads and hands
// npc/ir/valid to decode through registers. A redirect squashes any
// wrong-path instruction; an in-flight read is always allowed to finish
// (DRAIN) before fetching from the new target.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/squash_count outputs.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   squash_count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] tgt;
  logic [15:0] ibuf;
  logic [15:0] npc_q;
  logic [15:0] ir_q;
  logic        valid_q;

  logic [15:0] redirect_tgt;
  logic [15:0] pc_plus2;

  assign redirect_tgt = bus.redirect_pc & 16'hFFFE;
  assign pc_plus2     = pc + 16'd2;

  assign bus.imem_read    = rst_n && (state != HOLD);
  assign bus.imem_address = pc;
  assign bus.npc          = npc_q;
  assign bus.ir           = ir_q;
  assign bus.valid        = valid_q;

  // Fetch control: redirect beats stall, stall beats a memory response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      tgt     <= 16'h0000;
      ibuf    <= 16'h0000;
      npc_q   <= 16'h0000;
      ir_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.redirect) begin
            valid_q <= 1'b0;
            if (bus.imem_resp) begin
              pc <= redirect_tgt;
            end else begin
              tgt   <= redirect_tgt;
              state <= DRAIN;
            end
          end else if (bus.stall) begin
            if (bus.imem_resp) begin
              ibuf  <= bus.imem_rdata;
              state <= HOLD;
            end
          end else if (bus.imem_resp) begin
            ir_q    <= bus.imem_rdata;
            npc_q   <= pc_plus2;
            valid_q <= 1'b1;
            pc      <= pc_plus2;
          end else begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.redirect) begin
            pc      <= redirect_tgt;
            valid_q <= 1'b0;
            state   <= FETCH;
          end else if (!bus.stall) begin
            ir_q    <= ibuf;
            npc_q   <= pc_plus2;
            valid_q <= 1'b1;
            pc      <= pc_plus2;
            state   <= FETCH;
          end
        end
        DRAIN: begin
          valid_q <= 1'b0;
          if (bus.redirect) begin
            tgt <= redirect_tgt;
          end
          if (bus.imem_resp) begin
            pc    <= bus.redirect ? redirect_tgt : tgt;
            state <= FETCH;
          end
        end
        default: begin
          state   <= FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_evt;
  logic drop_evt;

  // Classify this cycle as an instruction hand-off and/or a squashed instruction.
  always_comb begin
    load_evt = 1'b0;
    drop_evt = 1'b0;
    case (state)
      FETCH: begin
        load_evt = !bus.redirect && !bus.stall && bus.imem_resp;
        drop_evt = bus.redirect && bus.imem_resp;
      end
      HOLD: begin
        load_evt = !bus.redirect && !bus.stall;
        drop_evt = bus.redirect;
      end
      DRAIN: begin
        drop_evt = bus.imem_resp;
      end
      default: begin
        load_evt = 1'b0;
        drop_evt = 1'b0;
      end
    endcase
  end

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count  <= 32'd0;
      squash_count <= 32'd0;
    end else begin
      if (load_evt) fetch_count <= fetch_count + 32'd1;
      if (drop_evt) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage.
// A variable-latency memory model answers reads; a transaction-level
// reference decides which fetched instructions reach decode and pushes
// them into a queue; a monitor pops and compares every cycle.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
  } exp_t;

  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .squash_count (squash_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // memory model state and per-cycle snapshots of the DUT request
  int          lat_mode = 1;
  int          lat      = 1;
  int          waited   = 0;
  logic [15:0] held_addr = 16'h0000;
  logic        mem_read_s = 1'b0;
  logic [15:0] mem_addr_s = 16'h0000;

  // reference model state
  logic [15:0] exp_pc = RESET_PC;
  logic        pend_valid = 1'b0;
  exp_t        pend;
  logic        inflight_wrong = 1'b0;
  int unsigned fetch_exp  = 0;
  int unsigned squash_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      default:  return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endcase
  endfunction

  function automatic int pick_lat(input int mode);
    if (mode < 0) return int'($urandom_range(0, 3));
    return mode;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit r, input logic [15:0] rpc, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.stall       = s;
      bus.redirect    = r;
      bus.redirect_pc = rpc;
    end
  endtask

  // Instruction memory: answers each request after lat cycles (0 = same cycle).
  initial begin
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      mem_read_s = bus.imem_read;
      mem_addr_s = bus.imem_address;
      if (!rst_n) begin
        checkOutput("read_in_reset", {31'd0, bus.imem_read}, 32'd0);
        bus.imem_resp = 1'b0;
        waited = 0;
        lat = pick_lat(lat_mode);
      end else begin
        if (pend_valid) checkOutput("read_in_hold", {31'd0, bus.imem_read}, 32'd0);
        if (waited > 0) checkOutput("request_kept", {31'd0, bus.imem_read}, 32'd1);
        if (bus.imem_read) begin
          if (waited > 0) checkOutput("addr_stable", {16'd0, bus.imem_address}, {16'd0, held_addr});
          held_addr = bus.imem_address;
          if (waited >= lat) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_address);
            waited = 0;
            lat = pick_lat(lat_mode);
          end else begin
            bus.imem_resp  = 1'b0;
            bus.imem_rdata = 16'hDEAD;
            waited++;
          end
        end else begin
          bus.imem_resp = 1'b0;
          waited = 0;
        end
      end
    end
  end

  // Reference: which fetched instructions reach decode, and in what order.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_pc = RESET_PC;
        pend_valid = 1'b0;
        inflight_wrong = 1'b0;
        fetch_exp = 0;
        squash_exp = 0;
      end else if (bus.redirect) begin
        if (pend_valid) begin
          pend_valid = 1'b0;
          squash_exp++;
        end
        if (bus.imem_resp) begin
          squash_exp++;
          inflight_wrong = 1'b0;
        end else if (mem_read_s) begin
          inflight_wrong = 1'b1;
        end
        exp_pc = bus.redirect_pc & 16'hFFFE;
      end else if (pend_valid) begin
        if (!bus.stall) begin
          sb.push_back(pend);
          fetch_exp++;
          pend_valid = 1'b0;
        end
      end else if (bus.imem_resp) begin
        if (inflight_wrong) begin
          squash_exp++;
          inflight_wrong = 1'b0;
        end else begin
          checkOutput("fetch_addr", {16'd0, mem_addr_s}, {16'd0, exp_pc});
          e.ir  = mem_word(exp_pc);
          e.npc = exp_pc + 16'd2;
          exp_pc = exp_pc + 16'd2;
          if (bus.stall) begin
            pend = e;
            pend_valid = 1'b1;
          end else begin
            sb.push_back(e);
            fetch_exp++;
          end
        end
      end
    end
  end

  // Monitor: compares decode-facing outputs every cycle against the queue.
  initial begin
    bit          p_stall, p_redir, p_rst;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_ir = 16'h0000;
    logic [15:0] exp_npc = 16'h0000;
    exp_t        e;
    forever begin
      @(posedge clk);
      p_stall = bus.stall;
      p_redir = bus.redirect;
      p_rst   = rst_n;
      @(negedge clk);
      if (!p_rst) begin
        exp_valid = 1'b0;
        exp_ir    = 16'h0000;
        exp_npc   = 16'h0000;
        checkOutput("reset_addr", {16'd0, bus.imem_address}, {16'd0, RESET_PC});
        sb.delete();
      end else if (p_redir) begin
        exp_valid = 1'b0;
      end else if (!p_stall) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          exp_valid = 1'b1;
          exp_ir    = e.ir;
          exp_npc   = e.npc;
        end else begin
          exp_valid = 1'b0;
        end
      end
      checkOutput("valid", {31'd0, bus.valid}, {31'd0, exp_valid});
      checkOutput("ir", {16'd0, bus.ir}, {16'd0, exp_ir});
      checkOutput("npc", {16'd0, bus.npc}, {16'd0, exp_npc});
      if (sb.size() != 0) begin
        checkOutput("queue_drained", sb.size(), 32'd0);
        sb.delete();
      end
`ifdef FETCH_PERF_CNT_EN
      if (p_rst) begin
        checkOutput("fetch_count", fetch_count, fetch_exp);
        checkOutput("squash_count", squash_count, squash_exp);
      end else begin
        checkOutput("fetch_count_rst", fetch_count, 32'd0);
        checkOutput("squash_count_rst", squash_count, 32'd0);
      end
`endif
    end
  end

  // Directed scenarios followed by a long randomized run.
  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    lat_mode = 1;
    applyStimulus(0, 0, 16'h0000, 3);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 16'h0000, 8);
    applyStimulus(1, 0, 16'h0000, 4);
    applyStimulus(0, 0, 16'h0000, 4);
    lat_mode = 3;
    applyStimulus(0, 0, 16'h0000, 1);
    applyStimulus(0, 1, 16'h3000, 1);
    applyStimulus(0, 0, 16'h0000, 12);
    lat_mode = 0;
    applyStimulus(0, 1, 16'h4000, 1);
    applyStimulus(0, 0, 16'h0000, 4);
    lat_mode = 1;
    applyStimulus(1, 0, 16'h0000, 3);
    applyStimulus(1, 1, 16'h5000, 1);
    applyStimulus(1, 0, 16'h0000, 2);
    applyStimulus(0, 0, 16'h0000, 6);
    applyStimulus(0, 1, 16'hFFFF, 1);
    applyStimulus(0, 0, 16'h0000, 6);
    lat_mode = 3;
    applyStimulus(0, 1, 16'h6000, 1);
    applyStimulus(0, 0, 16'h0000, 1);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, 0, 16'h0000, 2);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 16'h0000, 5);
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    16'($urandom), 1);
    end
    applyStimulus(0, 0, 16'h0000, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
